// File: rtl/loc_text_pkg.sv
// Shared types and constants for the location-text decoder: record kinds,
// error causes, FSM states, ASCII bytes of the grammar and the key strings.
package loc_text_pkg;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_REG   = 2'd1,
    KIND_STACK = 2'd2,
    KIND_ADDR  = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_SYNTAX = 3'd1,
    ERR_BADKEY = 3'd2,
    ERR_BADVAL = 3'd3,
    ERR_OVF    = 3'd4
  } err_e;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_KOPEN = 4'd1,
    ST_KEY   = 4'd2,
    ST_COLON = 4'd3,
    ST_VOPEN = 4'd4,
    ST_VSTR  = 4'd5,
    ST_VNUM  = 4'd6,
    ST_CLOSE = 4'd7,
    ST_EMIT  = 4'd8
  } state_e;

  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_BSLASH = 8'h5C;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_TAB    = 8'h09;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;

  // Key strings packed with the first character in bits [7:0], zero padded.
  localparam logic [63:0] KEY_REGISTER = 64'h7265747369676572;
  localparam logic [63:0] KEY_STACK    = 64'h0000006B63617473;
  localparam logic [63:0] KEY_ADDRESS  = 64'h0073736572646461;
  localparam logic [3:0]  KEY_REGISTER_LEN = 4'd8;
  localparam logic [3:0]  KEY_STACK_LEN    = 4'd5;
  localparam logic [3:0]  KEY_ADDRESS_LEN  = 4'd7;
  localparam logic [3:0]  KEY_MAX_LEN      = 4'd8;

  function automatic logic is_ws(input logic [7:0] b);
    return (b == CH_SPACE) || (b == CH_TAB) || (b == CH_LF) || (b == CH_CR);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_ZERO) && (b <= CH_NINE);
  endfunction

endpackage

// File: rtl/loc_dec_accum.sv
// Unsigned decimal accumulator for the address value. The overflow flag is a
// look-ahead: it reports that the digit presented this cycle would push the
// magnitude past the signed range, and in that case the digit is not applied.
module loc_dec_accum
  import loc_text_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        digit_stb,
  input  logic [3:0]  digit,
  input  logic        neg,
  output logic [63:0] value,
  output logic        ovf
);

  logic [64:0] acc_r;
  logic [68:0] next_s;
  logic [68:0] limit_s;

  // Candidate acc*10+d via shift-and-add, range limit and signed result.
  always_comb begin
    next_s  = {1'b0, acc_r, 3'b000} + {3'b000, acc_r, 1'b0} + {65'd0, digit};
    if (neg) begin
      limit_s = {5'd0, 1'b1, 63'd0};
    end else begin
      limit_s = {6'd0, {63{1'b1}}};
    end
    ovf = digit_stb && (next_s > limit_s);
    if (neg) begin
      value = 64'd0 - acc_r[63:0];
    end else begin
      value = acc_r[63:0];
    end
  end

  // Magnitude register: cleared at value start, updated on each in-range digit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_r <= 65'd0;
    end else if (digit_stb && !ovf) begin
      acc_r <= next_s[64:0];
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/loc_text_decoder.sv
// Streaming decoder for {"register": "NAME"}, {"stack": 0} and
// {"address": "DECIMAL"} objects: one ASCII byte per handshake in, one
// location record per well-formed object out, err pulse on malformed input.
module loc_text_decoder
  import loc_text_pkg::*;
#(
  parameter int REG_CHARS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_kind,
  output logic [8*REG_CHARS-1:0]       out_reg,
  output logic [$clog2(REG_CHARS+1)-1:0] out_reg_len,
  output logic [63:0]                  out_addr,
  output logic                         err,
  output logic [2:0]                   err_code,
  output logic [CNT_W-1:0]             rec_count
);

  localparam int LEN_W = $clog2(REG_CHARS + 1);

  state_e                 state_r, next_state_s;
  logic                   accept_s;
  err_e                   err_cause_s;
  logic                   err_fire_s;
  logic                   key_clr_s, key_st_s, kind_ld_s, vstr_clr_s, vstr_st_s;
  logic                   num_clr_s, neg_set_s, digit_stb_s, rec_load_s, rec_take_s;
  kind_e                  kind_s, kind_r;
  logic [63:0]            key_buf_r;
  logic [3:0]             key_len_r;
  logic [8*REG_CHARS-1:0] vbuf_r;
  logic [LEN_W-1:0]       vlen_r;
  logic                   neg_r, first_r, digits_r;
  logic [63:0]            acc_value_s;
  logic                   acc_ovf_s;
  logic                   in_ready_nxt_s;
  logic [8*REG_CHARS-1:0] rec_reg_s;
  logic [LEN_W-1:0]       rec_len_s;
  logic [63:0]            rec_addr_s;

  logic                   in_ready_r, out_valid_r, err_r;
  logic [1:0]             out_kind_r;
  logic [8*REG_CHARS-1:0] out_reg_r;
  logic [LEN_W-1:0]       out_reg_len_r;
  logic [63:0]            out_addr_r;
  logic [2:0]             err_code_r;
  logic [CNT_W-1:0]       rec_count_r;

  assign accept_s    = in_valid && in_ready_r;
  assign digit_stb_s = accept_s && (state_r == ST_VNUM) && is_digit(in_data);
  assign err_fire_s  = (err_cause_s != ERR_NONE);

  loc_dec_accum u_accum (
    .clk       (clk),
    .rst       (rst),
    .clear     (num_clr_s),
    .digit_stb (digit_stb_s),
    .digit     (in_data[3:0]),
    .neg       (neg_r),
    .value     (acc_value_s),
    .ovf       (acc_ovf_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-byte action decode; any error returns to IDLE.
  always_comb begin
    next_state_s = state_r;
    err_cause_s  = ERR_NONE;
    key_clr_s    = 1'b0;
    key_st_s     = 1'b0;
    kind_ld_s    = 1'b0;
    kind_s       = KIND_NONE;
    vstr_clr_s   = 1'b0;
    vstr_st_s    = 1'b0;
    num_clr_s    = 1'b0;
    neg_set_s    = 1'b0;
    rec_load_s   = 1'b0;
    rec_take_s   = 1'b0;
    if (state_r == ST_EMIT) begin
      if (out_ready) begin
        next_state_s = ST_IDLE;
        rec_take_s   = 1'b1;
      end else begin
        next_state_s = ST_EMIT;
      end
    end else if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (in_data == CH_LBRACE) next_state_s = ST_KOPEN;
          else                      next_state_s = ST_IDLE;
        end
        ST_KOPEN: begin
          if (is_ws(in_data)) begin
            next_state_s = ST_KOPEN;
          end else if (in_data == CH_QUOTE) begin
            next_state_s = ST_KEY;
            key_clr_s    = 1'b1;
          end else begin
            err_cause_s  = ERR_SYNTAX;
          end
        end
        ST_KEY: begin
          if (in_data == CH_QUOTE) begin
            if (key_len_r == KEY_REGISTER_LEN && key_buf_r == KEY_REGISTER) begin
              kind_s = KIND_REG;   kind_ld_s = 1'b1; next_state_s = ST_COLON;
            end else if (key_len_r == KEY_STACK_LEN && key_buf_r == KEY_STACK) begin
              kind_s = KIND_STACK; kind_ld_s = 1'b1; next_state_s = ST_COLON;
            end else if (key_len_r == KEY_ADDRESS_LEN && key_buf_r == KEY_ADDRESS) begin
              kind_s = KIND_ADDR;  kind_ld_s = 1'b1; next_state_s = ST_COLON;
            end else begin
              err_cause_s = ERR_BADKEY;
            end
          end else if (key_len_r == KEY_MAX_LEN) begin
            err_cause_s = ERR_BADKEY;
          end else begin
            key_st_s = 1'b1;
          end
        end
        ST_COLON: begin
          if (is_ws(in_data))            next_state_s = ST_COLON;
          else if (in_data == CH_COLON)  next_state_s = ST_VOPEN;
          else                           err_cause_s  = ERR_SYNTAX;
        end
        ST_VOPEN: begin
          if (is_ws(in_data)) begin
            next_state_s = ST_VOPEN;
          end else begin
            case (kind_r)
              KIND_REG: begin
                if (in_data == CH_QUOTE) begin
                  next_state_s = ST_VSTR; vstr_clr_s = 1'b1;
                end else begin
                  err_cause_s = ERR_SYNTAX;
                end
              end
              KIND_ADDR: begin
                if (in_data == CH_QUOTE) begin
                  next_state_s = ST_VNUM; num_clr_s = 1'b1;
                end else begin
                  err_cause_s = ERR_SYNTAX;
                end
              end
              KIND_STACK: begin
                if (in_data == CH_ZERO) next_state_s = ST_CLOSE;
                else                    err_cause_s  = ERR_BADVAL;
              end
              default: err_cause_s = ERR_SYNTAX;
            endcase
          end
        end
        ST_VSTR: begin
          if (in_data == CH_QUOTE) begin
            if (vlen_r == {LEN_W{1'b0}}) err_cause_s  = ERR_BADVAL;
            else                         next_state_s = ST_CLOSE;
          end else if (in_data == CH_BSLASH || in_data < CH_SPACE) begin
            err_cause_s = ERR_BADVAL;
          end else if (vlen_r == LEN_W'(REG_CHARS)) begin
            err_cause_s = ERR_OVF;
          end else begin
            vstr_st_s = 1'b1;
          end
        end
        ST_VNUM: begin
          if (is_ws(in_data)) begin
            next_state_s = ST_VNUM;
          end else if (in_data == CH_MINUS && first_r) begin
            neg_set_s = 1'b1;
          end else if (is_digit(in_data)) begin
            if (acc_ovf_s) err_cause_s  = ERR_OVF;
            else           next_state_s = ST_VNUM;
          end else if (in_data == CH_QUOTE) begin
            if (digits_r) next_state_s = ST_CLOSE;
            else          err_cause_s  = ERR_BADVAL;
          end else begin
            err_cause_s = ERR_BADVAL;
          end
        end
        ST_CLOSE: begin
          if (is_ws(in_data)) begin
            next_state_s = ST_CLOSE;
          end else if (in_data == CH_RBRACE) begin
            next_state_s = ST_EMIT;
            rec_load_s   = 1'b1;
          end else begin
            err_cause_s  = ERR_SYNTAX;
          end
        end
        default: next_state_s = ST_IDLE;
      endcase
      if (err_cause_s != ERR_NONE) next_state_s = ST_IDLE;
      else                         next_state_s = next_state_s;
    end else begin
      next_state_s = state_r;
    end
  end

  // Output-side decode: next in_ready and the record fields to latch.
  always_comb begin
    in_ready_nxt_s = (next_state_s != ST_EMIT);
    if (kind_r == KIND_REG) begin
      rec_reg_s = vbuf_r;
      rec_len_s = vlen_r;
    end else begin
      rec_reg_s = {(8*REG_CHARS){1'b0}};
      rec_len_s = {LEN_W{1'b0}};
    end
    if (kind_r == KIND_ADDR) rec_addr_s = acc_value_s;
    else                     rec_addr_s = 64'd0;
  end

  // Key collection buffer and matched record kind.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_buf_r <= 64'd0;
      key_len_r <= 4'd0;
      kind_r    <= KIND_NONE;
    end else begin
      if (key_clr_s) begin
        key_buf_r <= 64'd0;
        key_len_r <= 4'd0;
      end else if (key_st_s) begin
        for (int i = 0; i < 8; i++) begin
          if (key_len_r == 4'(i)) key_buf_r[8*i +: 8] <= in_data;
        end
        key_len_r <= key_len_r + 4'd1;
      end else begin
        key_buf_r <= key_buf_r;
        key_len_r <= key_len_r;
      end
      if (kind_ld_s) kind_r <= kind_s;
      else           kind_r <= kind_r;
    end
  end

  // Register-name buffer and decimal sign/digit bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      vbuf_r   <= {(8*REG_CHARS){1'b0}};
      vlen_r   <= {LEN_W{1'b0}};
      neg_r    <= 1'b0;
      first_r  <= 1'b1;
      digits_r <= 1'b0;
    end else begin
      if (vstr_clr_s) begin
        vbuf_r <= {(8*REG_CHARS){1'b0}};
        vlen_r <= {LEN_W{1'b0}};
      end else if (vstr_st_s) begin
        for (int i = 0; i < REG_CHARS; i++) begin
          if (vlen_r == LEN_W'(i)) vbuf_r[8*i +: 8] <= in_data;
        end
        vlen_r <= vlen_r + {{(LEN_W-1){1'b0}}, 1'b1};
      end else begin
        vbuf_r <= vbuf_r;
        vlen_r <= vlen_r;
      end
      if (num_clr_s) begin
        neg_r <= 1'b0; first_r <= 1'b1; digits_r <= 1'b0;
      end else if (neg_set_s) begin
        neg_r <= 1'b1; first_r <= 1'b0; digits_r <= digits_r;
      end else if (digit_stb_s) begin
        neg_r <= neg_r; first_r <= 1'b0; digits_r <= 1'b1;
      end else begin
        neg_r <= neg_r; first_r <= first_r; digits_r <= digits_r;
      end
    end
  end

  // Registered outputs: handshake flags, record fields, error and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      out_kind_r    <= 2'd0;
      out_reg_r     <= {(8*REG_CHARS){1'b0}};
      out_reg_len_r <= {LEN_W{1'b0}};
      out_addr_r    <= 64'd0;
      err_r         <= 1'b0;
      err_code_r    <= 3'd0;
      rec_count_r   <= {CNT_W{1'b0}};
    end else begin
      in_ready_r <= in_ready_nxt_s;
      err_r      <= err_fire_s;
      if (err_fire_s) err_code_r <= err_cause_s;
      else            err_code_r <= err_code_r;
      if (rec_load_s) begin
        out_valid_r   <= 1'b1;
        out_kind_r    <= kind_r;
        out_reg_r     <= rec_reg_s;
        out_reg_len_r <= rec_len_s;
        out_addr_r    <= rec_addr_s;
      end else if (rec_take_s) begin
        out_valid_r <= 1'b0;
        rec_count_r <= rec_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        out_valid_r <= out_valid_r;
        rec_count_r <= rec_count_r;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_kind    = out_kind_r;
  assign out_reg     = out_reg_r;
  assign out_reg_len = out_reg_len_r;
  assign out_addr    = out_addr_r;
  assign err         = err_r;
  assign err_code    = err_code_r;
  assign rec_count   = rec_count_r;

endmodule

// File: doc/loc_text_decoder.md
Name: loc_text_decoder

Overview:
- Streaming decoder for the serialized location text the compiler's object dumper emits: `{"register": "NAME"}`, `{"stack": 0}` or `{"address": "DECIMAL"}`.
- Consumes one ASCII byte per valid/ready handshake and emits one decoded location record per well-formed object.
- Reports malformed input and resynchronises on the next `{`.
- Sits between the object-dump byte stream and the location table.

Parameters:
- REG_CHARS, 8, maximum register-name length in bytes.
- CNT_W, 16, width of the emitted-record counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  ASCII byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  decoder accepts a byte this cycle.
- out_valid  out  1  decoded record valid.
- out_ready  in  1  consumer accepts the record.
- out_kind  out  2  record kind: 0 NONE, 1 REG, 2 STACK, 3 ADDR.
- out_reg  out  8*REG_CHARS  register name; byte 0 in bits [7:0]; zero-padded.
- out_reg_len  out  $clog2(REG_CHARS+1)  register-name length.
- out_addr  out  64  signed address, two's complement; 0 unless kind is ADDR.
- err  out  1  one-cycle pulse on a malformed byte.
- err_code  out  3  error cause; held until the next err.
- rec_count  out  CNT_W  count of records accepted by the consumer; wraps.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_kind=0, out_reg=0, out_reg_len=0, out_addr=0.
  - err=0, err_code=0, rec_count=0.
  - Reset mid-object discards the partial object; no record and no err result.
- Handshakes:
  - A byte is consumed when in_valid && in_ready.
  - A record is consumed when out_valid && out_ready.
  - in_ready is 0 only in state EMIT.
- Whitespace: bytes 0x20, 0x09, 0x0A and 0x0D are skipped in every state except KEY and VSTR.
- FSM (transitions fire on a consumed byte):
  - IDLE: `{` goes to KOPEN; any other byte is discarded silently.
  - KOPEN: `"` goes to KEY.
  - KEY: collect up to 8 bytes until `"`. Then match the key: "register" goes to COLON with kind REG; "stack" goes to COLON with kind STACK; "address" goes to COLON with kind ADDR. Any other key is error BADKEY. A 9th byte before `"` is also BADKEY.
  - COLON: `:` goes to VOPEN.
  - VOPEN:
    - REG: `"` goes to VSTR.
    - ADDR: `"` goes to VNUM.
    - STACK: `0` goes to CLOSE; any other byte is BADVAL.
  - VSTR: store bytes until `"`, then go to CLOSE. Length 0 is BADVAL. A byte beyond REG_CHARS is OVF. Bytes `\` and values below 0x20 are BADVAL.
  - VNUM:
    - An optional `-` is accepted as the first byte only.
    - Digits accumulate as acc = acc*10 + d.
    - Closing `"` goes to CLOSE.
    - No digits is BADVAL; a non-digit is BADVAL.
    - Magnitude above 2^63-1 (positive) or above 2^63 (negative) is OVF.
    - A result of -0 gives 0.
  - CLOSE: `}` goes to EMIT. Record fields are registered at this handshake, so out_valid rises the next cycle.
  - EMIT: hold all record outputs stable while out_valid=1. On out_ready, go to IDLE, increment rec_count, drop out_valid and raise in_ready in the next cycle.
  - Any unexpected byte in KOPEN, COLON, VOPEN or CLOSE is error SYNTAX.
- Errors:
  - err pulses the cycle after the offending byte; err_code is set in the same cycle.
  - The offending byte is consumed and the state goes to IDLE.
  - An offending `{` is dropped, not reused as a new object start.
  - err_code values: 1 SYNTAX, 2 BADKEY, 3 BADVAL, 4 OVF.
- Throughput: one byte per cycle; the only bubble is the EMIT cycle(s).
- Wrap: rec_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package loc_text_pkg holds:
  - kind enum (NONE/REG/STACK/ADDR);
  - err_code enum;
  - FSM state enum;
  - ASCII constants ({ } " : - \ and the whitespace bytes);
  - the three key strings as packed 64-bit constants.
- Sub-module loc_dec_accum: 65-bit unsigned decimal accumulator.
  - Ports: clear, digit strobe, digit, neg flag.
  - Outputs: signed 64-bit value, overflow flag.
  - Multiply-by-10 implemented as shift-and-add.

Test Plan:
- Stream `{"register": "r12"}` with in_valid held high → one record: kind=1, out_reg[23:0]="r12" (0x323172), len=3, addr=0, err never pulses, rec_count goes 0→1 after out_ready.
- Stream `{"address": "-9223372036854775808"}` then `{"address": "9223372036854775808"}` → first gives kind=3, addr=0x8000000000000000; second gives err with code 4 and no record.
- Stream `{"stack": 0}` with out_ready=0 for 5 cycles → out_valid held, in_ready=0 and the next bytes stall; record accepted at out_ready; in_ready returns high the next cycle.
- Stream `{"stack": 1}x{"foo": "a"}{"address": "7"}` → err code 3, then err code 2, then one record: kind=3, addr=7.
- Stream `{"register": "abcdefghi"}` with REG_CHARS=8 → err code 4 on byte `i`; the trailing bytes are discarded until the next `{`.
- Assert rst mid-way through `{"address": "12` then stream `{"stack":0}` → no err, one record with kind=2, rec_count=1.
